// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment scanner:
// active-high idle levels, slot phase type and the hex-to-segment table.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;
   localparam logic [7:0] AN_OFF  = 8'h00;

   typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

   // Active-high gfedcba patterns for 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bus between the register block and the scanner: frame contents in,
// frame-snapshot pulse back out.
interface seven_seg_scanner_if;
   logic [31:0] display;
   logic [7:0]  digit_enable;
   logic [7:0]  dp_in;
   logic        frame_start;

   modport master (output display, output digit_enable, output dp_in, input frame_start);
   modport slave  (input display, input digit_enable, input dp_in, output frame_start);
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit 7-segment display with per-slot dead-time
// and a per-frame snapshot of the displayed value.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int REFRESH_HZ   = 8_000,
   parameter int BLANK_CYCLES = 500,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                 clk,
   input  logic                 resetn,
   seven_seg_scanner_if.slave   bus,
   output logic [7:0]           an,
   output logic [6:0]           seg,
   output logic                 dp
);

   localparam int DIGIT_CYCLES = CLK_FREQ_HZ / REFRESH_HZ;
   localparam int CNT_W        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [7:0] AN_IDLE  = ACTIVE_LOW ? ~AN_OFF  : AN_OFF;
   localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic       DP_IDLE  = ACTIVE_LOW;

   if (BLANK_CYCLES >= DIGIT_CYCLES || DIGIT_CYCLES < 2) begin : g_bad_params
      $fatal(1, "seven_seg_scanner: need DIGIT_CYCLES >= 2 and BLANK_CYCLES < DIGIT_CYCLES");
   end

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       dig, dig_nxt;
   logic [31:0]      sh_display;
   logic [7:0]       sh_en, sh_dp;
   logic             snap;
   phase_t           phase;
   logic [31:0]      cur_display;
   logic [7:0]       cur_en, cur_dp;
   logic [3:0]       nibble;
   logic [6:0]       seg_dec;
   logic [7:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;

   hex_to_7seg u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   // On the snapshot edge the shadow regs are still stale, so bypass to the live inputs
   always_comb begin
      snap        = (cnt == '0) && (dig == 3'd0);
      cur_display = snap ? bus.display      : sh_display;
      cur_en      = snap ? bus.digit_enable : sh_en;
      cur_dp      = snap ? bus.dp_in        : sh_dp;
      nibble      = cur_display[{dig, 2'b00} +: 4];
      phase       = (32'(cnt) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;

      cnt_nxt = cnt + CNT_W'(1);
      dig_nxt = dig;
      if (cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
         cnt_nxt = '0;
         dig_nxt = dig + 3'd1;
      end

      an_nxt  = AN_IDLE;
      seg_nxt = SEG_IDLE;
      dp_nxt  = DP_IDLE;
      if (phase == PH_DRIVE && cur_en[dig]) begin
         an_nxt  = ACTIVE_LOW ? ~(8'd1 << dig) : (8'd1 << dig);
         seg_nxt = ACTIVE_LOW ? ~seg_dec : seg_dec;
         dp_nxt  = ACTIVE_LOW ? ~cur_dp[dig] : cur_dp[dig];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt             <= '0;
         dig             <= 3'd0;
         sh_display      <= '0;
         sh_en           <= '0;
         sh_dp           <= '0;
         an              <= AN_IDLE;
         seg             <= SEG_IDLE;
         dp              <= DP_IDLE;
         bus.frame_start <= 1'b0;
      end else begin
         cnt             <= cnt_nxt;
         dig             <= dig_nxt;
         an              <= an_nxt;
         seg             <= seg_nxt;
         dp              <= dp_nxt;
         bus.frame_start <= snap;
         if (snap) begin
            sh_display <= bus.display;
            sh_en      <= bus.digit_enable;
            sh_dp      <= bus.dp_in;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at 10 clocks per slot, 2 dead-time clocks, 80 per frame.
module tb_seven_seg_scanner;

   logic       clk;
   logic       resetn;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;
   int         n_checks = 0;
   int         n_fail   = 0;

   seven_seg_scanner_if ifc ();

   seven_seg_scanner #(
      .CLK_FREQ_HZ  (1000),
      .REFRESH_HZ   (100),
      .BLANK_CYCLES (2),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (ifc),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps one full frame; the first tick is the snapshot edge. segs holds the
   // hand-decoded active-high pattern of each digit, {d7,...,d0}.
   task automatic check_frame(input string tag, input logic [55:0] segs, input logic [7:0] en,
                              input logic [7:0] dpx, input int chg_pos, input logic [31:0] chg_val);
      int slot, c;
      logic lit;
      for (int i = 0; i < 80; i++) begin
         tick();
         slot = i / 10;
         c    = i % 10;
         lit  = (c >= 2) && en[slot];
         chk({tag, "_an"},  {24'd0, an},  lit ? {24'd0, ~(8'd1 << slot)} : 32'hFF);
         chk({tag, "_seg"}, {25'd0, seg}, lit ? {25'd0, ~segs[7*slot +: 7]} : 32'h7F);
         chk({tag, "_dp"},  {31'd0, dp},  lit ? {31'd0, ~dpx[slot]} : 32'd1);
         chk({tag, "_fs"},  {31'd0, ifc.frame_start}, (i == 0) ? 32'd1 : 32'd0);
         if (i == chg_pos) ifc.display = chg_val;
      end
   endtask

   initial begin
      logic [7:0] pan;
      logic [6:0] pseg;

      resetn           = 1'b0;
      ifc.display      = 32'h7654_3210;
      ifc.digit_enable = 8'hFF;
      ifc.dp_in        = 8'h00;
      tick();
      tick();
      chk("reset_an",  {24'd0, an},  32'hFF);
      chk("reset_seg", {25'd0, seg}, 32'h7F);
      chk("reset_dp",  {31'd0, dp},  32'd1);
      chk("reset_fs",  {31'd0, ifc.frame_start}, 32'd0);

      // All digits 0..7
      resetn = 1'b1;
      check_frame("t1", {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F},
                  8'hFF, 8'h00, -1, 32'h0);

      // Upper four digits disabled
      ifc.display      = 32'h0000_ABCD;
      ifc.digit_enable = 8'h0F;
      check_frame("t2", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h77, 7'h7C, 7'h39, 7'h5E},
                  8'h0F, 8'h00, -1, 32'h0);

      // Decimal points: digit 0 requested but disabled, digit 2 shown
      ifc.display      = 32'h0;
      ifc.digit_enable = 8'hFE;
      ifc.dp_in        = 8'h05;
      check_frame("t4", {8{7'h3F}}, 8'hFE, 8'h04, -1, 32'h0);

      // Mid-frame display change held off until next snapshot
      ifc.display      = 32'h1111_1111;
      ifc.digit_enable = 8'hFF;
      ifc.dp_in        = 8'h00;
      check_frame("t3a", {8{7'h06}}, 8'hFF, 8'h00, 30, 32'h2222_2222);
      check_frame("t3b", {8{7'h5B}}, 8'hFF, 8'h00, -1, 32'h0);

      // Reset asserted at frame clock 45 for three clocks
      for (int i = 0; i < 45; i++) tick();
      resetn = 1'b0;
      tick();
      chk("t5_an",  {24'd0, an},  32'hFF);
      chk("t5_seg", {25'd0, seg}, 32'h7F);
      chk("t5_dp",  {31'd0, dp},  32'd1);
      chk("t5_fs",  {31'd0, ifc.frame_start}, 32'd0);
      tick();
      tick();
      chk("t5_an_hold", {24'd0, an}, 32'hFF);
      resetn = 1'b1;
      check_frame("t5_rel", {8{7'h5B}}, 8'hFF, 8'h00, -1, 32'h0);

      // Random contents: one anode at most, segments steady while lit
      pan  = an;
      pseg = seg;
      for (int f = 0; f < 400; f++) begin
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(19) == 0) begin
               ifc.display      = $urandom;
               ifc.digit_enable = 8'($urandom);
               ifc.dp_in        = 8'($urandom);
            end
            tick();
            n_checks++;
            assert ($countones(~an) <= 1) else begin
               n_fail++;
               $error("FAIL rnd_onehot: observed an=%0h expected at most one low bit", an);
            end
            if (pan != 8'hFF && an != 8'hFF) begin
               n_checks++;
               assert (seg === pseg && an === pan) else begin
                  n_fail++;
                  $error("FAIL rnd_stable: observed an=%0h seg=%0h expected an=%0h seg=%0h",
                         an, seg, pan, pseg);
               end
            end
            pan  = an;
            pseg = seg;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
